// File: rtl/add_sub_pkg.sv
// Shared types and sizing helpers for the sequential adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Number of slices needed to cover the full operand width.
    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit ripple adder. Besides the sum and carry out it
// exposes the carry into its top bit so the caller can derive signed overflow.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] carry_s;

    // Bit-serial ripple chain across the slice.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
    end

    assign cout  = carry_s[SLICE];
    assign c_msb = carry_s[SLICE-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock, LSB first.
// Operands and results move through valid/ready handshakes.
// Optional build macro ADD_SUB_SATURATE_EN: clamps the result to the signed
// limit on overflow (cout/overflow still report the raw arithmetic).
module seq_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDX_W  = calc_idx_w(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
            $error("seq_add_sub: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;
    logic             out_valid_r;

    op_t              op_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             last_s;
    logic [SLICE-1:0] a_slice_s;
    logic [SLICE-1:0] b_slice_s;
    logic [SLICE-1:0] sum_s;
    logic             c_out_s;
    logic             c_msb_s;
    logic             overflow_s;
    logic [WIDTH-1:0] result_upd_s;
    logic [WIDTH-1:0] result_fin_s;

    assign op_s       = op_t'(op);
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign last_s     = (idx_r == LAST_IDX);
    assign overflow_s = c_msb_s ^ c_out_s;

    // Route the operand slice selected by the current index to the adder.
    always_comb begin
        a_slice_s = '0;
        b_slice_s = '0;
        for (int k = 0; k < NSLICE; k++) begin
            a_slice_s = (idx_r == IDX_W'(k)) ? a_r[k*SLICE +: SLICE] : a_slice_s;
            b_slice_s = (idx_r == IDX_W'(k)) ? b_r[k*SLICE +: SLICE] : b_slice_s;
        end
    end

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a     (a_slice_s),
        .b     (b_slice_s),
        .cin   (carry_r),
        .sum   (sum_s),
        .cout  (c_out_s),
        .c_msb (c_msb_s)
    );

    // Merge the fresh slice sum into the result word at the current index.
    always_comb begin
        result_upd_s = result_r;
        for (int k = 0; k < NSLICE; k++) begin
            result_upd_s[k*SLICE +: SLICE] = (idx_r == IDX_W'(k)) ? sum_s
                                                                  : result_r[k*SLICE +: SLICE];
        end
    end

`ifdef ADD_SUB_SATURATE_EN
    // Clamp to the signed limit in the direction of A's sign on overflow.
    always_comb begin
        result_fin_s = result_upd_s;
        if (overflow_s) begin
            if (a_r[WIDTH-1]) begin
                result_fin_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                result_fin_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            result_fin_s = result_upd_s;
        end
    end
`else
    // Wrapped two's-complement result; no clamping in this build.
    always_comb begin
        result_fin_s = result_upd_s;
    end
`endif

    // Control FSM plus operand, carry, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            result_r    <= '0;
            cout_r      <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= (op_s == OP_SUB) ? ~b : b;
                        carry_r <= op;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    carry_r <= c_out_s;
                    if (last_s) begin
                        result_r    <= result_fin_s;
                        cout_r      <= c_out_s;
                        overflow_r  <= overflow_s;
                        out_valid_r <= 1'b1;
                        idx_r       <= '0;
                        state_r     <= DONE;
                    end else begin
                        result_r <= result_upd_s;
                        idx_r    <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (accept_s) begin
                        a_r         <= a;
                        b_r         <= (op_s == OP_SUB) ? ~b : b;
                        carry_r     <= op;
                        idx_r       <= '0;
                        out_valid_r <= 1'b0;
                        state_r     <= RUN;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    idx_r       <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed self-checking bench for seq_add_sub at the default 32/8 geometry.
module tb_seq_add_sub;

`ifdef ADD_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    seq_add_sub #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // One complete transaction with a single-cycle out_ready handshake.
    task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vop, input logic [31:0] exp_raw, input logic [31:0] exp_sat,
                         input logic exp_c, input logic exp_v);
        int lat;
        a        = va;
        b        = vb;
        op       = vop;
        in_valid = 1'b1;
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        wait_valid(lat);
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_result"}, result, SAT ? exp_sat : exp_raw);
        check_val({tag, "_cout"}, 32'(cout), 32'(exp_c));
        check_val({tag, "_overflow"}, 32'(overflow), 32'(exp_v));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        op        = 1'b0;
        tick();
        tick();
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", result, 32'h0);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0);
        do_op("sub_5_7",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_7_5",  32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0);
        do_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);

        // Reset asserted while slice 2 is about to be processed.
        a        = 32'h0F0F_0F0F;
        b        = 32'h0101_0101;
        op       = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_result", result, 32'h0);
        check_val("midrst_cout", 32'(cout), 32'd0);
        check_val("midrst_overflow", 32'(overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("midrst_idle", 32'(out_valid), 32'd0);
        do_op("after_rst", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 32'h1010_1010, 1'b0, 1'b0);

        // Backpressure: DONE holds while out_ready stays low; new inputs ignored.
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;
        op       = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check_val("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            a        = 32'hDEAD_0000 + 32'(i);
            b        = 32'h0000_BEEF;
            op       = 1'b1;
            in_valid = 1'b1;
            tick();
            check_val("bp_result", result, 32'h2345_6789);
            check_val("bp_cout", 32'(cout), 32'd0);
            check_val("bp_overflow", 32'(overflow), 32'd0);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_handshake", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_val("bp_no_extra", 32'(out_valid), 32'd0);
        check_val("bp_idle_ready", 32'(in_ready), 32'd1);

        // Back-to-back with consumer always ready: accepts 5 cycles apart.
        a         = 32'hFFFF_FFFF;
        b         = 32'h0000_0001;
        op        = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        a = 32'h0000_0003;
        b = 32'h0000_0004;
        wait_valid(lat);
        check_val("b2b1_latency", 32'(lat), 32'd4);
        check_val("b2b1_result", result, 32'h0000_0000);
        check_val("b2b1_cout", 32'(cout), 32'd1);
        check_val("b2b1_overflow", 32'(overflow), 32'd0);
        check_val("b2b1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check_val("b2b2_latency", 32'(lat), 32'd4);
        check_val("b2b2_result", result, 32'h0000_0007);
        check_val("b2b2_cout", 32'(cout), 32'd0);
        check_val("b2b2_overflow", 32'(overflow), 32'd0);
        tick();
        out_ready = 1'b0;
        check_val("b2b2_released", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
